// File: rtl/sensor_timing_gen_mc.sv
// Multi-channel image-sensor timing and pixel generator (fval/lval/pixel data, N pixels per clock).
// Optional: define SENSOR_FVAL_LVAL_ALIGN_EN to fix the fval lead/tail at 3 clocks.
module sensor_timing_gen_mc #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned CHANNEL_NUM = 2,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                              clk_pix,
  input  logic                              reset,
  input  logic [CNT_WIDTH-1:0]              i_width,
  input  logic [CNT_WIDTH-1:0]              i_height,
  input  logic [CNT_WIDTH-1:0]              i_h_blank,
  input  logic [CNT_WIDTH-1:0]              i_v_blank,
  input  logic [CNT_WIDTH-1:0]              i_fval_lval_gap,
  input  logic [1:0]                        i_pattern,
  input  logic                              i_continue_lval,
  input  logic                              i_pause,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] o_pix_data
);
  localparam int unsigned CH_SHIFT = $clog2(CHANNEL_NUM);
  localparam int unsigned PIX_W    = DATA_WIDTH * CHANNEL_NUM;

  typedef enum logic [2:0] {IDLE, VBLANK, FV_LEAD, LINE, HBLANK, FV_TAIL} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] sh_width, sh_height, sh_h_blank, sh_v_blank, sh_gap;
  logic [1:0]           sh_pattern;
  logic                 sh_continue;
  logic [CNT_WIDTH-1:0] cnt;        // clocks spent in the current state; column index while in LINE
  logic [CNT_WIDTH-1:0] line_idx;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [15:0]          lfsr;

  logic [CNT_WIDTH-1:0] line_clks, v_len, h_len, gap_len;
  logic                 start_ok, last_line, enter_vblank, lfsr_fb;
  logic [PIX_W-1:0]     pix_c;

  assign line_clks = sh_width >> CH_SHIFT;
  assign v_len     = (sh_v_blank == '0) ? CNT_WIDTH'(1) : sh_v_blank;
  assign h_len     = (sh_h_blank == '0) ? CNT_WIDTH'(1) : sh_h_blank;
`ifdef SENSOR_FVAL_LVAL_ALIGN_EN
  assign gap_len   = CNT_WIDTH'(3);
`else
  assign gap_len   = (sh_gap == '0) ? CNT_WIDTH'(1) : sh_gap;
`endif
  assign start_ok     = !i_pause && ((i_width >> CH_SHIFT) != '0) && (i_height != '0);
  assign last_line    = (line_idx == sh_height - CNT_WIDTH'(1));
  assign enter_vblank = ((state == IDLE) && start_ok) ||
                        ((state == FV_TAIL) && (cnt == gap_len - CNT_WIDTH'(1)));
  assign lfsr_fb      = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] v,
                                                 input int unsigned k);
    logic [DATA_WIDTH-1:0] r;
    r = v;
    for (int unsigned i = 0; i < k; i++) r = {r[DATA_WIDTH-2:0], r[DATA_WIDTH-1]};
    return r;
  endfunction

  // Per-channel pixel value for the current LINE clock
  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] ch_val;
    always_comb begin
      ch_val = '0;
      case (sh_pattern)
        2'd0:    ch_val = DATA_WIDTH'(frame_cnt);
        2'd1:    ch_val = DATA_WIDTH'(line_idx);
        2'd2:    ch_val = DATA_WIDTH'(cnt * CNT_WIDTH'(CHANNEL_NUM) + CNT_WIDTH'(k));
        default: ch_val = rotl(lfsr[DATA_WIDTH-1:0], k);
      endcase
    end
    assign pix_c[k*DATA_WIDTH +: DATA_WIDTH] = ch_val;
  end

  // Frame geometry is frozen on VBLANK entry so mid-frame changes land on the next frame
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      sh_width    <= '0;
      sh_height   <= '0;
      sh_h_blank  <= '0;
      sh_v_blank  <= '0;
      sh_gap      <= '0;
      sh_pattern  <= 2'd0;
      sh_continue <= 1'b0;
    end else if (enter_vblank) begin
      sh_width    <= i_width;
      sh_height   <= i_height;
      sh_h_blank  <= i_h_blank;
      sh_v_blank  <= i_v_blank;
      sh_gap      <= i_fval_lval_gap;
      sh_pattern  <= i_pattern;
      sh_continue <= i_continue_lval;
    end
  end

  // Timing FSM; outputs reflect the state held during the previous clock
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      line_idx   <= '0;
      frame_cnt  <= '0;
      lfsr       <= LFSR_SEED;
      o_fval     <= 1'b0;
      o_lval     <= 1'b0;
      o_pix_data <= '0;
    end else begin
      o_fval     <= (state == FV_LEAD) || (state == LINE) || (state == HBLANK) || (state == FV_TAIL);
      o_lval     <= (state == LINE);
      o_pix_data <= (state == LINE) ? pix_c : '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_ok) state <= VBLANK;
        end
        VBLANK: begin
          if (cnt == v_len - CNT_WIDTH'(1)) begin
            cnt <= '0;
            if (i_pause || (line_clks == '0) || (sh_height == '0)) state <= IDLE;
            else                                                    state <= FV_LEAD;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        FV_LEAD: begin
          if (cnt == gap_len - CNT_WIDTH'(1)) begin
            cnt      <= '0;
            line_idx <= '0;
            state    <= LINE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        LINE: begin
          lfsr <= {lfsr_fb, lfsr[15:1]};
          if (cnt == line_clks - CNT_WIDTH'(1)) begin
            cnt <= '0;
            if (last_line) begin
              state <= FV_TAIL;
            end else begin
              line_idx <= line_idx + CNT_WIDTH'(1);
              state    <= sh_continue ? LINE : HBLANK;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        HBLANK: begin
          if (cnt == h_len - CNT_WIDTH'(1)) begin
            cnt   <= '0;
            state <= LINE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        FV_TAIL: begin
          if (cnt == gap_len - CNT_WIDTH'(1)) begin
            cnt       <= '0;
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            state     <= VBLANK;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_timing_gen_mc.sv
// Directed bench for sensor_timing_gen_mc: frame geometry, patterns, pause, reset and idle hold.
module tb_sensor_timing_gen_mc;
  localparam int unsigned DW = 10;
  localparam int unsigned CN = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = DW * CN;
`ifdef SENSOR_FVAL_LVAL_ALIGN_EN
  localparam int G = 3;
`else
  localparam int G = 5;
`endif
  localparam int V = 20;

  logic          clk_pix = 1'b0;
  logic          reset;
  logic [CW-1:0] i_width, i_height, i_h_blank, i_v_blank, i_fval_lval_gap;
  logic [1:0]    i_pattern;
  logic          i_continue_lval, i_pause;
  logic          o_fval, o_lval;
  logic [PW-1:0] o_pix_data;

  always #5 clk_pix = ~clk_pix;

  sensor_timing_gen_mc #(.DATA_WIDTH(DW), .CHANNEL_NUM(CN), .CNT_WIDTH(CW), .LFSR_SEED(16'hACE1)) dut (
    .clk_pix(clk_pix), .reset(reset), .i_width(i_width), .i_height(i_height),
    .i_h_blank(i_h_blank), .i_v_blank(i_v_blank), .i_fval_lval_gap(i_fval_lval_gap),
    .i_pattern(i_pattern), .i_continue_lval(i_continue_lval), .i_pause(i_pause),
    .o_fval(o_fval), .o_lval(o_lval), .o_pix_data(o_pix_data));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] w2(input int ch0, input int ch1);
    logic [DW-1:0] a, b;
    a = DW'(ch0);
    b = DW'(ch1);
    return {b, a};
  endfunction

  // Inputs applied mid-frame (during LINE) so they take effect on the following frame
  logic [CW-1:0] nxt_width;
  logic [1:0]    nxt_pattern;
  logic          nxt_cont, nxt_pause;

  int            m_fval_len, m_pulses, m_len_min, m_len_max, m_lead, m_zero_viol;
  logic [PW-1:0] m_first, m_second, m_last;

  task automatic wait_rise(input string tag);
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = o_fval;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_pix);
      if (o_fval && !prev) ok = 1'b1;
      prev = o_fval;
    end
    chk({tag, "_fval_rise_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic close_pulse(input int len);
    if (len < m_len_min) m_len_min = len;
    if (len > m_len_max) m_len_max = len;
  endtask

  // Called on the first fval-high sample; consumes samples until fval falls
  task automatic measure_frame();
    logic prev_l;
    int   c, cur, nw;
    m_pulses = 0; m_len_min = 1 << 30; m_len_max = 0; m_lead = -1; m_zero_viol = 0;
    m_first = '0; m_second = '0; m_last = '0;
    prev_l = 1'b0; cur = 0; c = 0; nw = 0;
    while (o_fval && c < 5000) begin
      c++;
      if (o_lval) begin
        if (!prev_l) begin
          m_pulses++;
          cur = 0;
          if (m_lead < 0) m_lead = c - 1;
        end
        cur++;
        if (nw == 0) m_first = o_pix_data;
        if (nw == 1) m_second = o_pix_data;
        m_last = o_pix_data;
        nw++;
      end else begin
        if (prev_l) close_pulse(cur);
        if (o_pix_data != '0) m_zero_viol++;
      end
      prev_l = o_lval;
      if (c == 20) begin
        i_width         = nxt_width;
        i_pattern       = nxt_pattern;
        i_continue_lval = nxt_cont;
        i_pause         = nxt_pause;
      end
      @(negedge clk_pix);
    end
    if (prev_l) close_pulse(cur);
    m_fval_len = c;
  endtask

  task automatic check_frame(input string tag, input int exp_len, input int exp_pulses, input int exp_plen);
    chk({tag, "_fval_len"}, 64'(m_fval_len), 64'(exp_len));
    chk({tag, "_lval_pulses"}, 64'(m_pulses), 64'(exp_pulses));
    chk({tag, "_lval_len_min"}, 64'(m_len_min), 64'(exp_plen));
    chk({tag, "_lval_len_max"}, 64'(m_len_max), 64'(exp_plen));
    chk({tag, "_fval_to_lval"}, 64'(m_lead), 64'(G));
    chk({tag, "_pix_zero_when_lval_low"}, 64'(m_zero_viol), 64'd0);
  endtask

  initial begin
    int n, hit;
    reset = 1'b1;
    i_width = 16; i_height = 16; i_h_blank = 4; i_v_blank = CW'(V); i_fval_lval_gap = 5;
    i_pattern = 2'd3; i_continue_lval = 1'b0; i_pause = 1'b0;
    nxt_width = 16; nxt_pattern = 2'd2; nxt_cont = 1'b0; nxt_pause = 1'b0;
    repeat (3) @(negedge clk_pix);
    chk("rst_fval", 64'(o_fval), 64'd0);
    chk("rst_lval", 64'(o_lval), 64'd0);
    chk("rst_pix", 64'(o_pix_data), 64'd0);
    reset = 1'b0;

    // Frame 0: LFSR pattern straight after reset
    wait_rise("f0");
    measure_frame();
    check_frame("f0", 16*8 + 15*4 + 2*G, 16, 8);
    chk("f0_lfsr_word0", 64'(m_first), 64'(w2(10'h0E1, 10'h1C2)));
    chk("f0_lfsr_word1", 64'(m_second), 64'(w2(10'h270, 10'h0E1)));

    // Frame 1: pixel ramp
    nxt_pattern = 2'd1; nxt_cont = 1'b1;
    wait_rise("f1");
    measure_frame();
    check_frame("f1", 16*8 + 15*4 + 2*G, 16, 8);
    chk("f1_ramp_first", 64'(m_first), 64'(w2(0, 1)));
    chk("f1_ramp_last", 64'(m_last), 64'(w2(14, 15)));

    // Frame 2: continuous lval, line index; width changed to 32 during its LINE
    nxt_pattern = 2'd0; nxt_cont = 1'b0; nxt_width = 32;
    wait_rise("f2");
    measure_frame();
    check_frame("f2", 128 + 2*G, 1, 128);
    chk("f2_line_first", 64'(m_first), 64'(w2(0, 0)));
    chk("f2_line_last", 64'(m_last), 64'(w2(15, 15)));

    // Frame 3: the wider window now applies
    nxt_width = 16;
    wait_rise("f3");
    measure_frame();
    check_frame("f3", 16*16 + 15*4 + 2*G, 16, 16);
    chk("f3_frame_cnt", 64'(m_first), 64'(w2(3, 3)));

    // Frame 4: pause raised mid-frame must not truncate it
    nxt_pause = 1'b1;
    wait_rise("f4");
    measure_frame();
    check_frame("f4", 16*8 + 15*4 + 2*G, 16, 8);
    chk("f4_frame_cnt", 64'(m_first), 64'(w2(4, 4)));
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_pix);
      if (o_fval) n++;
    end
    chk("pause_no_fval", 64'(n), 64'd0);
    i_pause = 1'b0; nxt_pause = 1'b0;
    hit = -1;
    for (int i = 1; i <= 500 && hit < 0; i++) begin
      @(negedge clk_pix);
      if (o_fval) hit = i;
    end
    chk("resume_latency", 64'(hit), 64'(V + 2));

    // Frame 5: counter continues without a gap; reset hits during LINE
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (o_lval) hit = 1;
      else @(negedge clk_pix);
    end
    chk("f5_lval_seen", 64'(hit), 64'd1);
    chk("f5_frame_cnt", 64'(o_pix_data), 64'(w2(5, 5)));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_fval", 64'(o_fval), 64'd0);
    chk("async_rst_lval", 64'(o_lval), 64'd0);
    chk("async_rst_pix", 64'(o_pix_data), 64'd0);
    repeat (2) @(negedge clk_pix);
    reset = 1'b0;
    wait_rise("post_rst");
    measure_frame();
    check_frame("post_rst", 16*8 + 15*4 + 2*G, 16, 8);
    chk("post_rst_frame_cnt", 64'(m_first), 64'(w2(0, 0)));

    // Zero width: block must stay idle
    i_width = 0;
    @(negedge clk_pix) reset = 1'b1;
    @(negedge clk_pix) reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_pix);
      if (o_fval || o_lval) n++;
    end
    chk("zero_width_idle", 64'(n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
